dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's EX/MEM stage and main memory.
//  Consumes the CPU's data address, store data, store strobe and EX/MEM opcode.
//  Produces load data and cache_resp_stall, which freezes the CPU's PC and IF/ID registers on a miss.
//  Word (32-bit) accesses only.
// PARAMETERS
//  LINES      64  number of cache lines (power of 2)
//  LINE_WORDS 4   32-bit words per line (power of 2)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset, asynchronous, active-high
//  cpu_opcode       in   7   EX/MEM opcode; 0000011 = load req, 0100011 = store req, other = no req
//  cpu_addr         in   32  byte address; [1:0] ignored
//  cpu_wdata        in   32  store data
//  cpu_rdata        out  32  load data, combinational, valid when req is load and cache_resp_stall=0
//  cache_resp_stall out  1   combinational; 1 = CPU must hold its request and freeze
//  mem_req_valid    out  1   memory request active
//  mem_req_rw       out  1   1 = line write-back, 0 = line fill
//  mem_addr         out  32  line-aligned address
//  mem_wdata        out  32*LINE_WORDS  victim line
//  mem_rdata        in   32*LINE_WORDS  fill line
//  mem_ready        in   1   one-cycle pulse; transfer complete
//  hit_count        out  32  hit counter
//  miss_count       out  32  miss counter
// BEHAVIOUR
//  Address split
//   - word offset = addr[2 +: log2(LINE_WORDS)]
//   - index = next log2(LINES) bits
//   - tag = remaining upper bits
//  FSM states: IDLE, WBACK, ALLOC.
//  IDLE
//   - hit = req & valid[idx] & tag match.
//   - Hit: stall=0. A load drives the word. A store writes the word at the clock edge, sets dirty, and increments hit_count.
//   - Miss: stall=1 in that same cycle. Latch addr, wdata and rw. Increment miss_count.
//   - On a miss, go to WBACK if valid&dirty, otherwise go to ALLOC.
//  WBACK
//   - stall=1, mem_req_valid=1, rw=1.
//   - mem_addr = {victim tag, idx, 0}, mem_wdata = victim line.
//   - On mem_ready, go to ALLOC.
//  ALLOC
//   - stall=1, mem_req_valid=1, rw=0.
//   - mem_addr = latched line address.
//   - On mem_ready: write mem_rdata into the line, set tag, valid=1, dirty=0, then go to IDLE.
//  Replay after the fill
//   - The held request replays in IDLE and hits.
//   - A store write and dirty set happen then, not during ALLOC.
//  Miss latency
//   - Clean miss: stall for memory latency + 1 cycle.
//   - Dirty miss: stall for 2 x memory latency + 1 cycle.
//  mem outputs hold stable while mem_req_valid=1; mem_req_valid drops the cycle after mem_ready.
//  mem_ready outside WBACK/ALLOC is ignored.
//  The CPU holds cpu_* while stalled. Memory requests use only the latched address.
//  Counters wrap modulo 2^32. A replay hit after a fill counts as a hit.
//  Reset (any time, including mid-transfer)
//   - State goes to IDLE; all valid and dirty bits cleared; counters cleared.
//   - mem_req_valid=0, stall=0.
//   - Data and tag arrays are not cleared.
//   - A pending transfer is abandoned; memory must tolerate an abandoned request.
//  Non-memory opcode: stall=0, no state change, cpu_rdata=0.
// STRUCTURE
//  dcache_defs.vh holds shared definitions:
//   - state encodings IDLE=2'd0, WBACK=2'd1, ALLOC=2'd2
//   - opcode constants OP_LOAD and OP_STORE
//   - derived widths OFF_W, IDX_W, TAG_W
//  Sub-module dcache_array holds the storage:
//   - tag, valid and dirty arrays, and the data line RAM
//   - 1 combinational read port, 1 synchronous write port (word or full line)
//  dcache_ctrl holds the FSM, the request latch and the counters.
// TESTING
//  T1: Reset, then load 0x100 with mem latency 3, fill line = {4,3,2,1}.
//      -> stall for 4 cycles, rdata=1, miss_count=1, hit_count=1.
//  T2: After T1, load 0x104, then 0x10C.
//      -> stall=0 both, rdata=2 then 4, hit_count=3.
//  T3: Store 0xDEAD to 0x108 (hit), then load 0x108.
//      -> rdata=0xDEAD, dirty[idx]=1, no mem request.
//  T4: After T3, load 0x500 (same index, new tag; LINES=64, LINE_WORDS=4).
//      -> WBACK with mem_addr=0x100, mem_wdata word2=0xDEAD.
//      -> then ALLOC with mem_addr=0x500; total stall = 2x latency + 1.
//  T5: Store miss to 0x200 (clean).
//      -> ALLOC at 0x200, then the store replays; the line has dirty=1 and holds the new word.
//  T6: Assert rst during ALLOC, before mem_ready.
//      -> mem_req_valid=0 and stall=0 immediately; a later load to 0x100 misses again.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: geometry, opcodes and FSM encoding shared by the data cache files.
package dcache_ctrl_pkg;
    localparam int LINES      = 64;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(LINES);
    localparam int TAG_W      = 32 - 2 - OFF_W - IDX_W;
    localparam int LINE_BITS  = 32 * LINE_WORDS;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic [1:0] {IDLE = 2'd0, WBACK = 2'd1, ALLOC = 2'd2} state_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side request/response and memory-side line transfer signals of the data cache.
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;
    logic [6:0]           cpu_opcode;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 cache_resp_stall;
    logic                 mem_req_valid;
    logic                 mem_req_rw;
    logic [31:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_ready;
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;
    modport slave (
        input  cpu_opcode, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cache_resp_stall, mem_req_valid, mem_req_rw, mem_addr, mem_wdata,
        hit_count, miss_count
    );
    modport master (
        output cpu_opcode, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cache_resp_stall, mem_req_valid, mem_req_rw, mem_addr, mem_wdata,
        hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl_array.sv
// dcache_ctrl_array: tag/valid/dirty state and line data of the direct-mapped cache.
// One combinational read port; one synchronous write port taking either a single word or a whole line.
module dcache_ctrl_array
    import dcache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 we_word_i,
    input  logic                 we_line_i,
    input  logic [OFF_W-1:0]     wr_off_i,
    input  logic [31:0]          wr_word_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic [LINE_BITS-1:0] wr_line_i
);
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;

    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_line_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (we_word_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tags and data survive reset; only the valid bits decide whether they are used.
    always_ff @(posedge clk) begin
        if (we_line_i) begin
            data_q[idx_i] <= wr_line_i;
            tag_q[idx_i]  <= wr_tag_i;
        end else if (we_word_i) begin
            data_q[idx_i][{wr_off_i, 5'd0} +: 32] <= wr_word_i;
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache between EX/MEM and main memory.
// A miss stalls the CPU, optionally writes back the dirty victim, fills the line, then replays as a hit.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst,
    dcache_ctrl_if.slave bus
);
    state_t                   state_q, state_d;
    logic [TAG_W+IDX_W-1:0]   line_q, line_d;
    logic [31:0]              hit_q, miss_q;
    logic                     is_ld, is_st, req, hit, miss;
    logic [OFF_W-1:0]         off;
    logic [IDX_W-1:0]         cpu_idx, idx;
    logic [TAG_W-1:0]         cpu_tag, rd_tag;
    logic                     rd_valid, rd_dirty;
    logic [LINE_BITS-1:0]     rd_line;

    assign is_ld   = bus.cpu_opcode == OP_LOAD;
    assign is_st   = bus.cpu_opcode == OP_STORE;
    assign req     = is_ld | is_st;
    assign off     = bus.cpu_addr[2 +: OFF_W];
    assign cpu_idx = bus.cpu_addr[2+OFF_W +: IDX_W];
    assign cpu_tag = bus.cpu_addr[31 -: TAG_W];
    // While a transfer is in flight the array is addressed only by the latched line.
    assign idx     = state_q == IDLE ? cpu_idx : line_q[IDX_W-1:0];
    assign hit     = state_q == IDLE && req && rd_valid && rd_tag == cpu_tag;
    assign miss    = state_q == IDLE && req && !hit;

    dcache_ctrl_array u_array (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (idx),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_line_o  (rd_line),
        .we_word_i  (hit && is_st),
        .we_line_i  (state_q == ALLOC && bus.mem_ready),
        .wr_off_i   (off),
        .wr_word_i  (bus.cpu_wdata),
        .wr_tag_i   (line_q[IDX_W +: TAG_W]),
        .wr_line_i  (bus.mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        if (miss) begin
            line_d  = {cpu_tag, cpu_idx};
            state_d = rd_valid && rd_dirty ? WBACK : ALLOC;
        end else if (state_q != IDLE && bus.mem_ready) begin
            state_d = state_q == WBACK ? ALLOC : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            hit_q   <= hit_q + {31'd0, hit};
            miss_q  <= miss_q + {31'd0, miss};
        end
    end

    assign bus.cache_resp_stall = !rst && (miss || state_q != IDLE);
    assign bus.mem_req_valid    = !rst && state_q != IDLE;
    assign bus.mem_req_rw       = state_q == WBACK;
    assign bus.mem_addr         = {state_q == WBACK ? rd_tag : line_q[IDX_W +: TAG_W],
                                   line_q[IDX_W-1:0], {(OFF_W+2){1'b0}}};
    assign bus.mem_wdata        = rd_line;
    assign bus.cpu_rdata        = is_ld && hit ? rd_line[{off, 5'd0} +: 32] : 32'd0;
    assign bus.hit_count        = hit_q;
    assign bus.miss_count       = miss_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random checks of dcache_ctrl against a flat-memory reference model.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();
    dcache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    bit [31:0] tbmem [int];
    bit [31:0] golden [int];
    int slot [64];
    bit dirty_m [64];
    int unsigned m_hit, m_miss;
    int lat = 1;
    bit active = 0, manual = 0;
    int exp_n, exp_victim, exp_line;
    bit exp_dirty, exp_load, wb_phase;
    bit [31:0] exp_rdata, exp_hit, exp_miss;
    int stall_cnt;
    bit wb_seen, al_seen;
    bit [31:0] last_rdata, wb_addr, wb_word2, al_addr;

    function automatic bit [31:0] init_w(int a);
        return a * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction
    function automatic bit [31:0] gold_w(int a);
        return golden.exists(a) ? golden[a] : init_w(a);
    endfunction
    function automatic bit [31:0] mem_w(int a);
        return tbmem.exists(a) ? tbmem[a] : init_w(a);
    endfunction
    function automatic logic [127:0] gold_line(int line);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) r[32*w +: 32] = gold_w(line * 4 + w);
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: answers each request after lat cycles; random stray mem_ready pulses when idle.
    int cnt = 0;
    bit prev_rdy = 0;
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ready = 1'b0;
            cnt = 0;
            prev_rdy = 0;
        end else if (!bus.mem_req_valid) begin
            bus.mem_ready = ($urandom_range(0, 3) == 0);
            cnt = 0;
            prev_rdy = 0;
        end else begin
            if (prev_rdy) cnt = 0;
            cnt++;
            bus.mem_ready = (cnt == lat);
            if (!bus.mem_req_rw) begin
                for (int w = 0; w < 4; w++) bus.mem_rdata[32*w +: 32] = mem_w(int'(bus.mem_addr >> 2) + w);
            end else if (bus.mem_ready) begin
                for (int w = 0; w < 4; w++) tbmem[int'(bus.mem_addr >> 2) + w] = bus.mem_wdata[32*w +: 32];
            end
            prev_rdy = bus.mem_ready;
        end
    end

    // Compare: k counts cycles since the request was presented.
    int k = 0;
    always @(negedge clk) begin
        #1;
        if (rst || manual) begin
            k = 0;
        end else if (!active) begin
            k = 0;
            chk("idle_stall", bus.cache_resp_stall, 0);
            chk("idle_mem_valid", bus.mem_req_valid, 0);
            chk("idle_rdata", bus.cpu_rdata, 0);
        end else begin
            chk("stall", bus.cache_resp_stall, k < exp_n);
            if (bus.cache_resp_stall) stall_cnt++;
            if (k > 0 && k < exp_n) begin
                wb_phase = exp_dirty && k <= lat;
                chk("mem_valid", bus.mem_req_valid, 1);
                chk("mem_rw", bus.mem_req_rw, wb_phase);
                chk("mem_addr", bus.mem_addr, (wb_phase ? exp_victim : exp_line) * 16);
                if (wb_phase) begin
                    chk("mem_wdata", bus.mem_wdata, gold_line(exp_victim));
                    if (!wb_seen) begin wb_seen = 1; wb_addr = bus.mem_addr; wb_word2 = bus.mem_wdata[95:64]; end
                end else if (!al_seen) begin
                    al_seen = 1;
                    al_addr = bus.mem_addr;
                end
            end else begin
                chk("mem_valid_off", bus.mem_req_valid, 0);
            end
            if (k == exp_n) begin
                if (exp_load) chk("rdata", bus.cpu_rdata, exp_rdata);
                last_rdata = bus.cpu_rdata;
                chk("hit_count", bus.hit_count, exp_hit);
                chk("miss_count", bus.miss_count, exp_miss);
                active = 0;
                k = 0;
            end else begin
                k++;
            end
        end
    end

    task automatic issue(bit st, int addr, bit [31:0] wd, int l);
        int wa = addr >> 2;
        int line = addr >> 4;
        int idx = line & 63;
        bit hit = slot[idx] == line;
        @(negedge clk);
        lat = l;
        exp_load = !st;
        exp_line = line;
        exp_rdata = gold_w(wa);
        exp_hit = m_hit;
        exp_dirty = !hit && dirty_m[idx];
        exp_victim = slot[idx];
        exp_n = hit ? 0 : exp_dirty ? 2 * l + 1 : l + 1;
        if (!hit) begin
            m_miss++;
            slot[idx] = line;
            dirty_m[idx] = 0;
        end
        exp_miss = m_miss;
        stall_cnt = 0;
        wb_seen = 0;
        al_seen = 0;
        bus.cpu_opcode = st ? OP_STORE : OP_LOAD;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wd;
        active = 1;
        for (int i = 0; i < 100 && active; i++) @(posedge clk);
        if (active) begin
            checks++;
            errors++;
            $display("FAIL timeout: request 0x%h still stalled after 100 cycles", addr);
            active = 0;
        end
        m_hit++;
        if (st) begin
            golden[wa] = wd;
            dirty_m[idx] = 1;
        end
    endtask

    task automatic idle(int n);
        @(negedge clk);
        bus.cpu_opcode = 7'b0110011;
        bus.cpu_addr = $urandom;
        bus.cpu_wdata = $urandom;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic model_reset();
        foreach (slot[i]) slot[i] = -1;
        foreach (dirty_m[i]) dirty_m[i] = 0;
        m_hit = 0;
        m_miss = 0;
        golden = tbmem;
    endtask

    initial begin
        bus.cpu_opcode = '0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        for (int w = 0; w < 4; w++) tbmem['h40 + w] = w + 1;
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        chk("rst_stall", bus.cache_resp_stall, 0);
        chk("rst_mem_valid", bus.mem_req_valid, 0);
        rst = 0;
        // T1: cold miss with latency 3
        issue(0, 'h100, 0, 3);
        chk("t1_stall_cycles", stall_cnt, 4);
        chk("t1_rdata", last_rdata, 1);
        idle(1);
        chk("t1_miss_count", bus.miss_count, 1);
        chk("t1_hit_count", bus.hit_count, 1);
        // T2: hits in the same line
        issue(0, 'h104, 0, 1);
        chk("t2_stall_a", stall_cnt, 0);
        chk("t2_rdata_a", last_rdata, 2);
        issue(0, 'h10C, 0, 1);
        chk("t2_rdata_b", last_rdata, 4);
        idle(1);
        chk("t2_hit_count", bus.hit_count, 3);
        // T3: store hit then load
        issue(1, 'h108, 'hDEAD, 1);
        issue(0, 'h108, 0, 1);
        chk("t3_rdata", last_rdata, 'hDEAD);
        chk("t3_stall", stall_cnt, 0);
        // T4: conflicting tag evicts the dirty line
        issue(0, 'h500, 0, 2);
        chk("t4_stall_cycles", stall_cnt, 5);
        chk("t4_wb_addr", wb_addr, 'h100);
        chk("t4_wb_word2", wb_word2, 'hDEAD);
        chk("t4_alloc_addr", al_addr, 'h500);
        // T5: clean store miss, replayed store leaves the line dirty
        issue(1, 'h200, 'h5555AAAA, 3);
        chk("t5_stall_cycles", stall_cnt, 4);
        chk("t5_alloc_addr", al_addr, 'h200);
        issue(0, 'h200, 0, 1);
        chk("t5_rdata", last_rdata, 'h5555AAAA);
        issue(0, 'h600, 0, 1);
        chk("t5_wb_addr", wb_addr, 'h200);
        chk("t5_stall_dirty", stall_cnt, 3);
        // T6: reset in the middle of a fill
        manual = 1;
        @(negedge clk);
        lat = 4;
        bus.cpu_opcode = OP_LOAD;
        bus.cpu_addr = 'h100;
        repeat (2) @(negedge clk);
        #2;
        chk("t6_alloc_valid", bus.mem_req_valid, 1);
        chk("t6_alloc_rw", bus.mem_req_rw, 0);
        rst = 1;
        #1;
        chk("t6_rst_mem_valid", bus.mem_req_valid, 0);
        chk("t6_rst_stall", bus.cache_resp_stall, 0);
        bus.cpu_opcode = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        manual = 0;
        issue(0, 'h100, 0, 2);
        chk("t6_remiss_stall", stall_cnt, 3);
        idle(1);
        chk("t6_miss_count", bus.miss_count, 1);
        chk("t6_hit_count", bus.hit_count, 1);
        // Random traffic over a few indices and tags to force hits, conflicts and write-backs
        repeat (400) begin
            int r = $urandom_range(0, 7);
            if (r == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                int a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
                issue(r[0], a, $urandom, $urandom_range(1, 4));
            end
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
